// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Largest value representable in the given number of BCD digits.
    function automatic logic [63:0] bcd_max(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // 9 + 3 = 12 at most, so the sum never carries out of the digit.
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with saturation, leading-zero
// blanking mask and registered outputs that update only on the done pulse.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iSTART,
    input  logic [BIN_W-1:0]            iBIN,
    output logic                        oBUSY,
    output logic                        oDONE,
    output logic [DIGIT_W*DIGITS-1:0]   oDIG,
    output logic [DIGITS-1:0]           oBLANK,
    output logic                        oOVF
);

    localparam int                ACC_W    = DIGIT_W * DIGITS;
    localparam int                CNT_W    = $clog2(BIN_W + 1);
    localparam logic [63:0]       MAXV     = bcd_max(DIGITS);
    localparam logic [CNT_W-1:0]  LAST_IT  = CNT_W'(BIN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [ACC_W-1:0]    dig_q, dig_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                ovfo_q, ovfo_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_shift;
    logic [DIGITS-1:0]   blank_next;
    logic                zero_run;
    logic                sat;
    logic [BIN_W-1:0]    max_bin;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i (acc_q[DIGIT_W*g +: DIGIT_W]),
            .digit_o (acc_adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
    // Saturating at MAXV keeps the accumulator from ever overflowing.
    assign sat       = 64'(iBIN) > MAXV;
    assign max_bin   = MAXV[BIN_W-1:0];

    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run && (acc_shift[DIGIT_W*i +: DIGIT_W] == '0);
            blank_next[i] = zero_run;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        blank_d = blank_q;
        ovfo_d  = ovfo_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    bin_d   = sat ? max_bin : iBIN;
                    ovf_d   = sat;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                acc_d  = acc_shift;
                bin_d  = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IT) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dig_d   = acc_shift;
                    blank_d = blank_next;
                    ovfo_d  = ovf_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
            blank_q <= BLANK_RST;
            ovfo_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            ovfo_q  <= ovfo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign oBUSY  = busy_q;
    assign oDONE  = done_q;
    assign oDIG   = dig_q;
    assign oBLANK = blank_q;
    assign oOVF   = ovfo_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed scoreboard bench for bin2bcd_seq at default parameters.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [23:0] dig;
        logic [5:0]  blank;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] bin;
    logic        busy;
    logic        done;
    logic [23:0] dig;
    logic [5:0]  blank;
    logic        ovf;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iSTART (start),
        .iBIN   (bin),
        .oBUSY  (busy),
        .oDONE  (done),
        .oDIG   (dig),
        .oBLANK (blank),
        .oOVF   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [19:0] b);
        exp_t e;
        int   v;
        logic run;
        v     = (int'(b) > 999999) ? 999999 : int'(b);
        e.ovf = (int'(b) > 999999);
        for (int i = 0; i < 6; i++) begin
            e.dig[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.blank = '0;
        run = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            run        = run && (e.dig[4*i +: 4] == 4'd0);
            e.blank[i] = run;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_dig"},   32'(dig),   32'(e.dig));
            check({tag, "_blank"}, 32'(blank), 32'(e.blank));
            check({tag, "_ovf"},   32'(ovf),   32'(e.ovf));
        end
    endtask

    // Start one conversion; optionally pulse iSTART again at a given busy cycle.
    task automatic run_conv(input string tag, input logic [19:0] b,
                            input int inj_at, input logic [19:0] inj_bin);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        sb_q.push_back(model(b));
        lat = 0; busy_cnt = 0; seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            start = (lat == inj_at);
            if (lat == inj_at) bin = inj_bin;
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd21);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd20);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        compare_out(tag);
    endtask

    task automatic no_done_window(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check({tag, "_no_extra_done"}, 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #1;
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_dig",   32'(dig),   32'h0);
        check("reset_blank", 32'(blank), 32'b111110);
        check("reset_ovf",   32'(ovf),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_conv("c123456", 20'd123456, 0, '0);
        check("c123456_dig_const", 32'(dig), 32'h123456);
        check("c123456_blank_const", 32'(blank), 32'b000000);

        run_conv("zero", 20'd0, 0, '0);
        check("zero_blank_const", 32'(blank), 32'b111110);
        run_conv("c42", 20'd42, 0, '0);
        check("c42_dig_const", 32'(dig), 32'h000042);
        check("c42_blank_const", 32'(blank), 32'b111100);

        run_conv("sat", 20'd1048575, 0, '0);
        check("sat_dig_const", 32'(dig), 32'h999999);
        check("sat_ovf_const", 32'(ovf), 32'd1);
        run_conv("max", 20'd999999, 0, '0);
        check("max_ovf_const", 32'(ovf), 32'd0);

        run_conv("busy_ign", 20'd5, 10, 20'd7);
        check("busy_ign_dig_const", 32'(dig), 32'h000005);
        no_done_window("busy_ign", 30);

        @(negedge clk);
        bin   = 20'd1;
        start = 1'b1;
        sb_q.push_back(model(20'd1));
        n = 0; k = 0;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (done) begin
                k++;
                check($sformatf("b2b%0d_latency", k), 32'(n), 32'(21 * k));
                compare_out($sformatf("b2b%0d", k));
                if (k < 3) begin
                    bin = 20'(k + 1);
                    sb_q.push_back(model(20'(k + 1)));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        sb_q.delete();
        no_done_window("b2b", 25);

        run_conv("c777", 20'd777, 0, '0);
        @(negedge clk);
        bin   = 20'd888;
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy),  32'd0);
        check("mid_rst_dig",   32'(dig),   32'h0);
        check("mid_rst_blank", 32'(blank), 32'b111110);
        check("mid_rst_ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done_window("mid_rst", 30);
        check("mid_rst_dig_held", 32'(dig), 32'h0);
        run_conv("c9", 20'd9, 0, '0);
        check("c9_dig_const", 32'(dig), 32'h000009);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
